// File: rtl/synth_voice_mixer.sv
// Purpose: mix NUM_VOICES gated, gain-scaled voices into one saturated mono sample (one MAC per cycle).
// Latency: NUM_VOICES+2 cycles from accept to the out_valid pulse; one frame per NUM_VOICES+2 cycles.
// Backpressure: in_ready is low while busy; frames offered then are dropped and flagged on overrun.
module synth_voice_mixer #(
  parameter int AUDIO_WIDTH = 32,
  parameter int NUM_VOICES  = 8,
  parameter int GAIN_WIDTH  = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_VOICES*AUDIO_WIDTH-1:0]     voices_in,
  input  logic [NUM_VOICES-1:0]                 note_on,
  input  logic [NUM_VOICES*GAIN_WIDTH-1:0]      gains_in,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  output logic signed [AUDIO_WIDTH-1:0]         out_sample,
  output logic                                  out_valid,
  output logic [$clog2(NUM_VOICES+1)-1:0]       active_count,
  output logic                                  clip,
  output logic                                  overrun
);

  localparam int IDX_W  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int CNT_W  = $clog2(NUM_VOICES + 1);
  localparam int PROD_W = AUDIO_WIDTH + GAIN_WIDTH + 1;
  // Wide enough that NUM_VOICES full-scale products can never wrap.
  localparam int ACC_W  = AUDIO_WIDTH + GAIN_WIDTH + $clog2(NUM_VOICES) + 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-AUDIO_WIDTH+1){1'b0}}, {(AUDIO_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-AUDIO_WIDTH+1){1'b1}}, {(AUDIO_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_SAT   = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic signed [AUDIO_WIDTH-1:0] voice_q [NUM_VOICES];
  logic        [GAIN_WIDTH-1:0]  gain_q  [NUM_VOICES];
  logic        [NUM_VOICES-1:0]  mask_q;
  logic        [IDX_W-1:0]       idx;
  logic signed [ACC_W-1:0]       acc;

  logic                          accept;
  logic signed [PROD_W-1:0]      voice_ext;
  logic signed [PROD_W-1:0]      gain_ext;
  logic signed [PROD_W-1:0]      prod;
  logic signed [PROD_W-1:0]      prod_sh;
  logic signed [ACC_W-1:0]       addend;
  logic signed [AUDIO_WIDTH-1:0] sat_val;
  logic                          sat_clip;

  function automatic logic [CNT_W-1:0] popcount(input logic [NUM_VOICES-1:0] m);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      c = c + CNT_W'(m[i]);
    end
    return c;
  endfunction

  assign in_ready = (state == S_IDLE);
  assign accept   = in_valid && in_ready;
  // Combinational so the flag lines up with the exact cycles a frame is refused.
  assign overrun  = in_valid && !in_ready;

  // Gain is unsigned Q1.(GAIN_WIDTH-1): zero-extend it, multiply signed, then an
  // arithmetic shift drops the fraction (floors toward negative infinity).
  assign voice_ext = PROD_W'(voice_q[idx]);
  assign gain_ext  = PROD_W'($signed({1'b0, gain_q[idx]}));
  assign prod      = voice_ext * gain_ext;
  assign prod_sh   = prod >>> (GAIN_WIDTH - 1);
  assign addend    = ACC_W'(prod_sh);

  // Clamp the accumulated sum into the output sample range and flag clipping.
  always_comb begin
    sat_val  = acc[AUDIO_WIDTH-1:0];
    sat_clip = 1'b0;
    if (acc > SAT_MAX) begin
      sat_val  = SAT_MAX[AUDIO_WIDTH-1:0];
      sat_clip = 1'b1;
    end else if (acc < SAT_MIN) begin
      sat_val  = SAT_MIN[AUDIO_WIDTH-1:0];
      sat_clip = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: one pass over every voice slot, then a single saturate cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (in_valid) state_nxt = S_ACCUM;
      S_ACCUM: if (idx == LAST_IDX) state_nxt = S_SAT;
      S_SAT:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Frame capture, multiply-accumulate and result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        voice_q[i] <= '0;
        gain_q[i]  <= '0;
      end
      mask_q       <= '0;
      idx          <= '0;
      acc          <= '0;
      out_sample   <= '0;
      out_valid    <= 1'b0;
      active_count <= '0;
      clip         <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (accept) begin
        for (int i = 0; i < NUM_VOICES; i++) begin
          voice_q[i] <= voices_in[i*AUDIO_WIDTH +: AUDIO_WIDTH];
          gain_q[i]  <= gains_in[i*GAIN_WIDTH +: GAIN_WIDTH];
        end
        mask_q <= note_on;
        idx    <= '0;
        acc    <= '0;
      end
      if (state == S_ACCUM) begin
        if (mask_q[idx]) begin
          acc <= acc + addend;
        end
        if (idx != LAST_IDX) begin
          idx <= idx + IDX_W'(1);
        end
      end
      if (state == S_SAT) begin
        out_sample   <= sat_val;
        clip         <= sat_clip;
        active_count <= popcount(mask_q);
        out_valid    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_synth_voice_mixer.sv
// Purpose: scoreboard bench for synth_voice_mixer at default parameters.
// Latency: expects out_valid NUM_VOICES+2 cycles after each accepted frame.
// Backpressure: drives in_valid while busy to exercise frame dropping and overrun.
module tb_synth_voice_mixer;

  localparam int AW = 32;
  localparam int NV = 8;
  localparam int GW = 8;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NV*AW-1:0]      voices_in;
  logic [NV-1:0]         note_on;
  logic [NV*GW-1:0]      gains_in;
  logic                  in_valid;
  logic                  in_ready;
  logic signed [AW-1:0]  out_sample;
  logic                  out_valid;
  logic [3:0]            active_count;
  logic                  clip;
  logic                  overrun;

  logic signed [AW-1:0]  voice_a [NV];
  logic [GW-1:0]         gain_a  [NV];

  logic signed [AW-1:0]  exp_sample_q [$];
  bit                    exp_clip_q   [$];
  logic [3:0]            exp_cnt_q    [$];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Pack the per-voice stimulus arrays onto the flat DUT buses.
  always_comb begin
    voices_in = '0;
    gains_in  = '0;
    for (int i = 0; i < NV; i++) begin
      voices_in[i*AW +: AW] = voice_a[i];
      gains_in[i*GW +: GW]  = gain_a[i];
    end
  end

  synth_voice_mixer #(.AUDIO_WIDTH(AW), .NUM_VOICES(NV), .GAIN_WIDTH(GW)) dut (
    .clk(clk), .rst(rst), .voices_in(voices_in), .note_on(note_on), .gains_in(gains_in),
    .in_valid(in_valid), .in_ready(in_ready), .out_sample(out_sample), .out_valid(out_valid),
    .active_count(active_count), .clip(clip), .overrun(overrun)
  );

  task automatic set_all(input logic signed [AW-1:0] v, input logic [GW-1:0] g, input logic [NV-1:0] m);
    for (int i = 0; i < NV; i++) begin
      voice_a[i] = v;
      gain_a[i]  = g;
    end
    note_on = m;
  endtask

  // Offer the current stimulus for one cycle and record what it must produce.
  task automatic drive_frame(input logic signed [AW-1:0] es, input bit ec, input logic [3:0] en);
    in_valid = 1'b1;
    exp_sample_q.push_back(es);
    exp_clip_q.push_back(ec);
    exp_cnt_q.push_back(en);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Returns the cycle index (accept cycle = 0) of the first out_valid, or -1.
  task automatic wait_result(output int cyc);
    cyc = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (out_valid) begin
        cyc = c;
        return;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    in_valid = 1'b0;
    set_all('0, '0, '0);
    #12;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_sample !== 0) begin n_err++; $display("FAIL reset_out_sample: got %0d want 0", out_sample); end
    n_cmp++; if (active_count !== 4'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", active_count); end
    n_cmp++; if (clip !== 1'b0) begin n_err++; $display("FAIL reset_clip: got %b want 0", clip); end
    n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Accept one frame and compare its result, latency included, against the scoreboard.
  task automatic run_and_check(input string name);
    int cyc;
    logic signed [AW-1:0] es;
    bit ec;
    logic [3:0] en;
    wait_result(cyc);
    es = exp_sample_q.pop_front();
    ec = exp_clip_q.pop_front();
    en = exp_cnt_q.pop_front();
    n_cmp++; if (cyc !== 10) begin n_err++; $display("FAIL %s_latency: got %0d want 10", name, cyc); end
    n_cmp++; if (out_sample !== es) begin n_err++; $display("FAIL %s_sample: got %0d want %0d", name, out_sample, es); end
    n_cmp++; if (clip !== ec) begin n_err++; $display("FAIL %s_clip: got %b want %b", name, clip, ec); end
    n_cmp++; if (active_count !== en) begin n_err++; $display("FAIL %s_count: got %0d want %0d", name, active_count, en); end
  endtask

  task automatic test_unity();
    set_all(32'sd1000, 8'd128, 8'hFF);
    drive_frame(32'sd8000, 1'b0, 4'd8);
    run_and_check("unity");
    @(posedge clk);
    #1;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL unity_pulse_width: got %b want 0", out_valid); end
    n_cmp++; if (out_sample !== 32'sd8000) begin n_err++; $display("FAIL unity_hold: got %0d want 8000", out_sample); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_masking();
    set_all('0, 8'd128, 8'h05);
    for (int i = 0; i < NV; i++) voice_a[i] = 32'(100 * (i + 1));
    drive_frame(32'sd400, 1'b0, 4'd2);
    run_and_check("mask05");
    @(posedge clk);
    #1;
    note_on = 8'h80;
    drive_frame(32'sd800, 1'b0, 4'd1);
    run_and_check("mask80");
    @(posedge clk);
    #1;
    note_on = 8'h00;
    drive_frame(32'sd0, 1'b0, 4'd0);
    run_and_check("mask00");
    @(posedge clk);
    #1;
  endtask

  task automatic test_gain();
    set_all(32'sd12345, 8'd200, 8'h01);
    voice_a[0] = -32'sd3;
    gain_a[0]  = 8'd64;
    drive_frame(-32'sd2, 1'b0, 4'd1);
    run_and_check("gain_floor");
    @(posedge clk);
    #1;
    voice_a[0] = 32'sd1000;
    gain_a[0]  = 8'd255;
    drive_frame(32'sd1992, 1'b0, 4'd1);
    run_and_check("gain_255");
    @(posedge clk);
    #1;
  endtask

  task automatic test_saturation();
    set_all(32'sh7FFFFFFF, 8'd255, 8'hFF);
    drive_frame(32'sh7FFFFFFF, 1'b1, 4'd8);
    run_and_check("sat_pos");
    @(posedge clk);
    #1;
    @(negedge clk);
    n_cmp++; if (clip !== 1'b1) begin n_err++; $display("FAIL sat_clip_hold: got %b want 1", clip); end
    @(posedge clk);
    #1;
    set_all(32'sh80000000, 8'd255, 8'hFF);
    drive_frame(32'sh80000000, 1'b1, 4'd8);
    run_and_check("sat_neg");
    @(posedge clk);
    #1;
    set_all(32'sd1000, 8'd128, 8'h01);
    drive_frame(32'sd1000, 1'b0, 4'd1);
    run_and_check("sat_clear");
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    int got_a;
    int got_b;
    logic signed [AW-1:0] es;
    bit ec;
    logic [3:0] en;
    got_a = -1;
    got_b = -1;
    set_all(32'sd1000, 8'd128, 8'hFF);
    in_valid = 1'b1;
    exp_sample_q.push_back(32'sd8000);
    exp_clip_q.push_back(1'b0);
    exp_cnt_q.push_back(4'd8);
    for (int c = 0; c <= 21; c++) begin
      if (c == 1) set_all(32'sd7, 8'd128, 8'h03);
      if (c == 11) in_valid = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (overrun !== ((c >= 1) && (c <= 9))) begin
        n_err++; $display("FAIL b2b_overrun_c%0d: got %b want %b", c, overrun, ((c >= 1) && (c <= 9)));
      end
      if (out_valid && exp_sample_q.size() > 0) begin
        if (got_a < 0) got_a = c; else got_b = c;
        es = exp_sample_q.pop_front();
        ec = exp_clip_q.pop_front();
        en = exp_cnt_q.pop_front();
        n_cmp++; if (out_sample !== es) begin n_err++; $display("FAIL b2b_sample_c%0d: got %0d want %0d", c, out_sample, es); end
        n_cmp++; if (active_count !== en) begin n_err++; $display("FAIL b2b_count_c%0d: got %0d want %0d", c, active_count, en); end
        n_cmp++; if (clip !== ec) begin n_err++; $display("FAIL b2b_clip_c%0d: got %b want %b", c, clip, ec); end
      end
      if (c == 10) begin
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready_c10: got %b want 1", in_ready); end
        exp_sample_q.push_back(32'sd14);
        exp_clip_q.push_back(1'b0);
        exp_cnt_q.push_back(4'd2);
      end
      @(posedge clk);
      #1;
    end
    n_cmp++; if (got_a !== 10) begin n_err++; $display("FAIL b2b_first_cycle: got %0d want 10", got_a); end
    n_cmp++; if (got_b !== 20) begin n_err++; $display("FAIL b2b_second_cycle: got %0d want 20", got_b); end
  endtask

  task automatic test_reset_mid();
    set_all(32'sh7FFFFFFF, 8'd255, 8'hFF);
    drive_frame(32'sh7FFFFFFF, 1'b1, 4'd8);
    run_and_check("pre_reset");
    @(posedge clk);
    #1;
    set_all(32'sd1000, 8'd128, 8'hFF);
    drive_frame(32'sd8000, 1'b0, 4'd8);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    #1;
    void'(exp_sample_q.pop_back());
    void'(exp_clip_q.pop_back());
    void'(exp_cnt_q.pop_back());
    n_cmp++; if (out_sample !== 0) begin n_err++; $display("FAIL rstmid_sample: got %0d want 0", out_sample); end
    n_cmp++; if (clip !== 1'b0) begin n_err++; $display("FAIL rstmid_clip: got %b want 0", clip); end
    n_cmp++; if (active_count !== 4'd0) begin n_err++; $display("FAIL rstmid_count: got %0d want 0", active_count); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_in_ready: got %b want 1", in_ready); end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_ready_after: got %b want 1", in_ready); end
    set_all(32'sd5, 8'd128, 8'hFF);
    drive_frame(32'sd40, 1'b0, 4'd8);
    run_and_check("post_reset");
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_unity();
    test_masking();
    test_gain();
    test_saturation();
    test_back_to_back();
    test_reset_mid();
    n_cmp++; if (exp_sample_q.size() !== 0) begin n_err++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_sample_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
